// File: rtl/tt_um_serial_adder.sv
// tt_um_serial_adder
// Bit-serial adder/subtractor for the Tiny Tapeout user-project wrapper.
// One full adder and one carry flop process the operands LSB first, one
// bit per enabled clock. WIDTH may range from 2 to 8; the result sits in
// the low WIDTH bits of uo_out, and the upper bits read as zero.
// Control arrives on uio_in: [0] load_a, [1] load_b, [2] start, [3] sub,
// [4] acc. Status leaves on uio_out: [5] carry_out, [6] done, [7] busy.

module tt_um_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // The bit counter only has to reach WIDTH-1.
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

   stateT            r_state;
   stateT            w_nextState;

   // Programmer-visible operand and result registers.
   logic [WIDTH-1:0] r_aReg;
   logic [WIDTH-1:0] r_bReg;
   logic [WIDTH-1:0] r_resReg;
   logic             r_carryOut;

   // Serial datapath: operand shifters, partial sum, carry, bit count, mode.
   logic [WIDTH-1:0] r_shiftA;
   logic [WIDTH-1:0] r_shiftB;
   logic [WIDTH-1:0] r_sumShift;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic             r_sub;

   // Decoded control pins.
   logic             w_loadA;
   logic             w_loadB;
   logic             w_start;
   logic             w_subIn;
   logic             w_accIn;
   logic [WIDTH-1:0] w_uiData;

   // Qualified events.
   logic             w_idleOrDone;
   logic             w_startAccept;
   logic             w_loadAccept;
   logic             w_shiftStep;
   logic             w_lastBit;

   // Full-adder outputs for the current bit.
   logic             w_sumBit;
   logic             w_carryNext;

   // Collects the pins and mode bit that no logic reads.
   logic             w_unused;

   assign w_loadA  = uio_in[0];
   assign w_loadB  = uio_in[1];
   assign w_start  = uio_in[2];
   assign w_subIn  = uio_in[3];
   assign w_accIn  = uio_in[4];
   assign w_uiData = ui_in[WIDTH-1:0];

   // Start and load are only accepted in IDLE or DONE. Start takes
   // priority, so any load in the same cycle as a start is dropped.
   assign w_idleOrDone  = (r_state == IDLE) || (r_state == DONE);
   assign w_startAccept = ena && w_idleOrDone && w_start;
   assign w_loadAccept  = ena && w_idleOrDone && !w_start;
   assign w_shiftStep   = ena && (r_state == SHIFT);
   assign w_lastBit     = (r_count == CW'(WIDTH - 1));

   assign w_sumBit    = r_shiftA[0] ^ r_shiftB[0] ^ r_carry;
   assign w_carryNext = (r_shiftA[0] & r_shiftB[0])
                      | (r_shiftA[0] & r_carry)
                      | (r_shiftB[0] & r_carry);

   assign w_unused = &{1'b0, ui_in, uio_in[7:5], r_sub};

   // State register. Reset also aborts an operation that is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state. A start leaves IDLE or DONE. The last enabled shift
   // enters DONE, and DONE holds until the next accepted start.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_startAccept) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (w_shiftStep && w_lastBit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (w_startAccept) begin
               w_nextState = SHIFT;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand registers load from ui_in. Setting load_a and load_b
   // together writes the same value into both registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aReg <= '0;
         r_bReg <= '0;
      end else if (w_loadAccept) begin
         if (w_loadA) begin
            r_aReg <= w_uiData;
         end
         if (w_loadB) begin
            r_bReg <= w_uiData;
         end
      end
   end

   // Serial datapath. Start primes the shifters. Subtraction is done as
   // A + ~B + 1, so the carry starts at 1. Each enabled SHIFT cycle
   // consumes one bit of each operand and pushes one sum bit in at the
   // MSB of the partial-sum register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shiftA   <= '0;
         r_shiftB   <= '0;
         r_sumShift <= '0;
         r_carry    <= 1'b0;
         r_count    <= '0;
         r_sub      <= 1'b0;
      end else if (w_startAccept) begin
         r_shiftA   <= w_accIn ? r_resReg : r_aReg;
         r_shiftB   <= w_subIn ? ~r_bReg : r_bReg;
         r_sumShift <= '0;
         r_carry    <= w_subIn;
         r_count    <= '0;
         r_sub      <= w_subIn;
      end else if (w_shiftStep) begin
         r_shiftA   <= r_shiftA >> 1;
         r_shiftB   <= r_shiftB >> 1;
         r_sumShift <= {w_sumBit, r_sumShift[WIDTH-1:1]};
         r_carry    <= w_carryNext;
         r_count    <= r_count + 1'b1;
      end
   end

   // The visible result changes only on the completing edge. Until then,
   // uo_out keeps showing the previous answer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resReg   <= '0;
         r_carryOut <= 1'b0;
      end else if (w_shiftStep && w_lastBit) begin
         r_resReg   <= {w_sumBit, r_sumShift[WIDTH-1:1]};
         r_carryOut <= w_carryNext;
      end
   end

   // Output pins are driven only from registers. Unused result bits and
   // the unused uio bits read as zero.
   always_comb begin
      uo_out                = 8'h00;
      uo_out[WIDTH-1:0]     = r_resReg;
      uio_out               = 8'h00;
      uio_out[5]            = r_carryOut;
      uio_out[6]            = (r_state == DONE);
      uio_out[7]            = (r_state == SHIFT);
      uio_oe                = 8'hE0;
   end

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// tb_tt_um_serial_adder
// Runs an 8-bit and a 4-bit adder side by side from the same pins. Each
// one is checked every cycle against an arithmetic model of the operand
// and result registers.

module tb_tt_um_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo8, uioOut8, oe8;
   logic [7:0] uo4, uioOut4, oe4;

   int passCount  = 0;
   int checkCount = 0;

   // Model state. Index 0 is the 8-bit instance and index 1 is the 4-bit one.
   int         widths [2] = '{8, 4};
   logic [7:0] mA     [2];
   logic [7:0] mB     [2];
   logic [7:0] mRes   [2];
   logic       mCout  [2];
   logic       mDone  [2];

   tt_um_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo8), .uio_out(uioOut8), .uio_oe(oe8)
   );

   tt_um_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo4), .uio_out(uioOut4), .uio_oe(oe4)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   function automatic logic [7:0] obsUo(int i);
      return (i == 0) ? uo8 : uo4;
   endfunction

   function automatic logic [7:0] obsUio(int i);
      return (i == 0) ? uioOut8 : uioOut4;
   endfunction

   function automatic logic [7:0] maskOf(int i);
      return (widths[i] == 8) ? 8'hFF : 8'h0F;
   endfunction

   function automatic void modelClear();
      for (int i = 0; i < 2; i++) begin
         mA[i] = 0; mB[i] = 0; mRes[i] = 0; mCout[i] = 0; mDone[i] = 0;
      end
   endfunction

   // Load driver. The caller must be in IDLE or DONE.
   task automatic load(input logic [7:0] val, input bit la, input bit lb);
      ui_in  = val;
      uio_in = {6'b0, lb, la};
      @(negedge clk);
      uio_in = 8'h00;
      for (int i = 0; i < 2; i++) begin
         if (la) mA[i] = val & maskOf(i);
         if (lb) mB[i] = val & maskOf(i);
      end
   endtask

   // Starts one operation and checks every cycle until the 8-bit result
   // is done. Optionally stalls with ena low, or pulses junk control
   // while shifting.
   task automatic runOp(input bit sub, input bit acc, input int stallAt,
                        input int stallLen, input bit junk, input string tag);
      logic [8:0] full;
      logic [7:0] opA, opB;
      logic [7:0] newRes [2];
      logic       newC   [2];
      logic       busyE;
      logic [7:0] expUo, expUio;
      int         enabled;
      int         stallCnt;
      bit         wasEna;
      for (int i = 0; i < 2; i++) begin
         opA       = acc ? mRes[i] : mA[i];
         opB       = sub ? (~mB[i] & maskOf(i)) : mB[i];
         full      = {1'b0, opA} + {1'b0, opB} + 9'(sub);
         newRes[i] = full[7:0] & maskOf(i);
         newC[i]   = full[widths[i]];
      end
      uio_in = {3'b000, acc, sub, 3'b100};
      @(negedge clk);
      uio_in   = 8'h00;
      enabled  = 0;
      stallCnt = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            busyE  = (enabled < widths[i]);
            expUo  = busyE ? mRes[i] : newRes[i];
            expUio = {busyE, !busyE, busyE ? mCout[i] : newC[i], 5'b0};
            checkCount++;
            if (obsUo(i) !== expUo)
               $display("[TB] FAIL %s_uo w%0d step%0d got %h want %h",
                        tag, widths[i], enabled, obsUo(i), expUo);
            else passCount++;
            checkCount++;
            if (obsUio(i) !== expUio)
               $display("[TB] FAIL %s_uio w%0d step%0d got %h want %h",
                        tag, widths[i], enabled, obsUio(i), expUio);
            else passCount++;
         end
         if (enabled >= 8) break;
         if (stallCnt < stallLen && enabled == stallAt) begin
            ena = 1'b0;
            stallCnt++;
         end
         if (junk && enabled == 2) begin
            uio_in = 8'h07 | (8'($urandom_range(0, 3)) << 3);
            ui_in  = 8'($urandom);
         end
         wasEna = ena;
         @(negedge clk);
         if (wasEna) enabled++;
         ena    = 1'b1;
         uio_in = 8'h00;
      end
      checkCount++;
      if (enabled < 8)
         $display("[TB] FAIL %s_timeout got %0d want 8", tag, enabled);
      else passCount++;
      for (int i = 0; i < 2; i++) begin
         mRes[i] = newRes[i]; mCout[i] = newC[i]; mDone[i] = 1'b1;
      end
   endtask

   // Asynchronous reset is applied between edges, and then the outputs
   // are checked for staying put after reset is released.
   task automatic test_reset();
      rst_n = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      modelClear();
      for (int i = 0; i < 2; i++) begin
         checkCount++;
         if (obsUo(i) !== 8'h00)
            $display("[TB] FAIL reset_uo w%0d got %h want 00", widths[i], obsUo(i));
         else passCount++;
         checkCount++;
         if (obsUio(i) !== 8'h00)
            $display("[TB] FAIL reset_uio w%0d got %h want 00", widths[i], obsUio(i));
         else passCount++;
      end
      checkCount++;
      if (oe8 !== 8'hE0 || oe4 !== 8'hE0)
         $display("[TB] FAIL reset_oe got %h/%h want e0", oe8, oe4);
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkCount++;
         if (obsUo(i) !== 8'h00 || obsUio(i) !== 8'h00)
            $display("[TB] FAIL post_reset_idle w%0d got %h/%h want 00/00",
                     widths[i], obsUo(i), obsUio(i));
         else passCount++;
      end
   endtask

   task automatic test_add();
      load(8'h5A, 1, 0);
      load(8'h3C, 0, 1);
      runOp(0, 0, -1, 0, 0, "add");
   endtask

   // A load in DONE must leave done set. An accumulate must not disturb A.
   task automatic test_accumulate();
      load(8'h70, 0, 1);
      for (int i = 0; i < 2; i++) begin
         checkCount++;
         if (obsUio(i) !== {2'b01, mCout[i], 5'b0} || obsUo(i) !== mRes[i])
            $display("[TB] FAIL load_in_done w%0d got %h/%h want %h/%h", widths[i],
                     obsUio(i), obsUo(i), {2'b01, mCout[i], 5'b0}, mRes[i]);
         else passCount++;
      end
      runOp(0, 1, -1, 0, 0, "acc");
      runOp(0, 0, -1, 0, 0, "acc_then_add");
   endtask

   task automatic test_overflow();
      load(8'hFF, 1, 0);
      load(8'h01, 0, 1);
      runOp(0, 0, -1, 0, 0, "ovf_ff_01");
      load(8'h03, 0, 1);
      runOp(0, 0, -1, 0, 0, "ovf_ff_03");
   endtask

   task automatic test_subtract();
      load(8'h20, 1, 0);
      load(8'h10, 0, 1);
      runOp(1, 0, -1, 0, 0, "sub_nob");
      load(8'h10, 1, 0);
      load(8'h20, 0, 1);
      runOp(1, 0, -1, 0, 0, "sub_borrow");
   endtask

   task automatic test_ignore_during_shift();
      load(8'hA7, 1, 0);
      load(8'h36, 0, 1);
      runOp(0, 0, -1, 0, 1, "junk");
   endtask

   task automatic test_stall();
      load(8'h9C, 1, 0);
      load(8'h4B, 0, 1);
      runOp(0, 0, 3, 3, 0, "stall");
   endtask

   task automatic test_back_to_back();
      load(8'h11, 1, 1);
      runOp(0, 0, -1, 0, 0, "b2b_first");
      runOp(1, 1, -1, 0, 0, "b2b_second");
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            load(8'($urandom), 1, 1);
         end else begin
            load(8'($urandom), 1, 0);
            load(8'($urandom), 0, 1);
         end
         runOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 0, "rand");
      end
   endtask

   // Reset three bits into a shift must clear everything immediately.
   task automatic test_reset_mid_shift();
      load(8'h5A, 1, 0);
      load(8'h3C, 0, 1);
      uio_in = 8'h04;
      @(negedge clk);
      uio_in = 8'h00;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checkCount++;
         if (obsUo(i) !== 8'h00 || obsUio(i) !== 8'h00)
            $display("[TB] FAIL reset_mid_shift w%0d got %h/%h want 00/00",
                     widths[i], obsUo(i), obsUio(i));
         else passCount++;
      end
      modelClear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load(8'h01, 0, 1);
      runOp(0, 0, -1, 0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_add();
      test_accumulate();
      test_overflow();
      test_subtract();
      test_ignore_during_shift();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
